// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
//   arb_state_t : arbiter FSM states
//   grant_t     : which requester owns the current access
//   CNT_W       : width of the wait-state counter (covers MEM_LAT up to 15)
package mem_arb_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } grant_t;

  // The port that is not g; used for alternating priority.
  function automatic grant_t other_port(input grant_t g);
    return (g == GNT_IF) ? GNT_D : GNT_IF;
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-state down-counter for one memory access.
//   clk, reset  : clock, synchronous active-high reset
//   load        : load load_value (takes priority over dec)
//   load_value  : cycles remaining minus one at the start of an access
//   dec         : decrement by one
//   value       : current count
//   zero        : value == 0, i.e. this is the last access cycle
module mem_wait_counter
  import mem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (dec) begin
      value <= value - CNT_W'(1);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch (IF)
// and data access (D). Each access holds mem_en for MEM_LAT cycles, then the
// granted port sees a one-cycle ready pulse. Contention alternates priority.
//   clk, reset                  : clock, synchronous active-high reset
//   if_req/if_addr              : fetch request, held until if_ready
//   if_rdata/if_ready           : fetched word, valid with the ready pulse
//   d_req/d_we/d_addr/d_wdata   : load/store request, held until d_ready
//   d_rdata/d_ready             : load data, valid with the ready pulse
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_rdata         : memory side; rdata valid in last cycle
//   if_stall/d_stall            : req & ~ready, for pipeline hold logic
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              if_stall,
  output logic              d_stall
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LAT - 1);

  arb_state_t       state, state_next;
  grant_t           last_grant;   // port of the current/most recent access
  grant_t           pick;
  logic             grant_go;
  logic             if_elig, d_elig;
  logic             we_q;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;

  mem_wait_counter u_wait (
    .clk        (clk),
    .reset      (reset),
    .load       (grant_go),
    .load_value (LOAD_VAL),
    .dec        ((state == ACCESS) && (cnt != '0)),
    .value      (cnt),
    .zero       (cnt_zero)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    grant_go   = 1'b0;
    pick       = other_port(last_grant);

    // In RESP the port just served may still hold req high; exclude it.
    if_elig = if_req && !((state == RESP) && (last_grant == GNT_IF));
    d_elig  = d_req  && !((state == RESP) && (last_grant == GNT_D));

    if (if_elig && d_elig) begin
      pick = other_port(last_grant);
    end else if (d_elig) begin
      pick = GNT_D;
    end else begin
      pick = GNT_IF;
    end

    case (state)
      IDLE, RESP: begin
        if (if_elig || d_elig) begin
          grant_go   = 1'b1;
          state_next = ACCESS;
        end else begin
          state_next = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_zero) begin
          state_next = RESP;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GNT_IF;
      we_q       <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      state <= state_next;

      if (grant_go) begin
        last_grant <= pick;
        if (pick == GNT_D) begin
          mem_addr  <= d_addr;
          mem_wdata <= d_wdata;
          we_q      <= d_we;
        end else begin
          mem_addr <= if_addr;
          we_q     <= 1'b0;
        end
      end

      // Read data is only valid in the last access cycle; stores leave the
      // port's rdata register untouched.
      if ((state == ACCESS) && cnt_zero && !we_q) begin
        if (last_grant == GNT_D) begin
          d_rdata <= mem_rdata;
        end else begin
          if_rdata <= mem_rdata;
        end
      end
    end
  end

  assign mem_en   = (state == ACCESS);
  assign mem_we   = mem_en && we_q;
  assign if_ready = (state == RESP) && (last_grant == GNT_IF);
  assign d_ready  = (state == RESP) && (last_grant == GNT_D);
  assign if_stall = if_req && !if_ready;
  assign d_stall  = d_req && !d_ready;

endmodule
